// File: rtl/npc_fetch_sequencer_pkg.sv
// Shared types and constants for the next-PC / instruction-fetch sequencer.
// Holds the fetch FSM state encoding, the NPC select codes and the reset PC.
package npc_fetch_sequencer_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FULL
  } fetch_state_e;

  // NPCSelect encoding shared with the ID-stage decoder that raises redirects.
  typedef enum logic [2:0] {
    NPC_PC4 = 3'b000,
    NPC_BR  = 3'b001,
    NPC_J   = 3'b010,
    NPC_JR  = 3'b011
  } npc_sel_e;

endpackage

// File: rtl/npc_fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
// The master issues req/addr and holds them until ack; the slave returns rdata with ack.
interface npc_fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  import npc_fetch_sequencer_pkg::*;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);

endinterface

// File: rtl/npc_fetch_sequencer_fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer that parks an acknowledged fetch
// while IF/ID is stalled; load captures, drop releases.
module npc_fetch_sequencer_fetch_skid_buf
  import npc_fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drop,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [ADDR_W-1:0]  pc_d,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the payload is deliberately left without reset; it is only looked at while valid=1,
  // and valid itself is reset.
  always_ff @(posedge clk) begin
    if (load) begin
      instr <= instr_d;
      pc    <= pc_d;
    end
  end

endmodule

// File: rtl/npc_fetch_sequencer.sv
// PC register and instruction-fetch sequencer for the pipelined MIPS core: issues imem
// requests, applies ID-stage redirects after the branch delay slot, and feeds IF/ID under stall.
module npc_fetch_sequencer
  import npc_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall_i,
  input  logic                        redirect_valid_i,
  input  logic [ADDR_W-1:0]           redirect_target_i,
  npc_fetch_sequencer_if.master       imem,
  output logic                        if_valid_o,
  output logic [INSTR_W-1:0]          instr_o,
  output logic [ADDR_W-1:0]           if_pc_o,
  output logic [ADDR_W-1:0]           pc_o
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pend_t_q;
  logic               pend_v_q;
  logic [ADDR_W-1:0]  target;
  logic               fetch_done;

  logic               buf_load, buf_drop, buf_valid;
  logic [INSTR_W-1:0] buf_instr;
  logic [ADDR_W-1:0]  buf_pc;

  assign target     = redirect_target_i & ~ADDR_W'(3);
  assign fetch_done = (state_q == WAIT) && imem.ack;
  assign pc_o       = pc_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The fetch of pc is the delay slot: a redirect seen before its ack waits in pend_t until then.
  // With no fetch outstanding (IDLE/FULL) the delay slot is already fetched, so pc jumps at once.
  // A second redirect while one is pending would be a branch in a delay slot and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      pend_v_q <= 1'b0;
      pend_t_q <= '0;
    end else if (fetch_done) begin
      pc_q     <= pend_v_q ? pend_t_q : (redirect_valid_i ? target : pc_q + ADDR_W'(4));
      pend_v_q <= 1'b0;
    end else if (redirect_valid_i && !pend_v_q) begin
      if (state_q == WAIT) begin
        pend_t_q <= target;
        pend_v_q <= 1'b1;
      end else begin
        pc_q <= target;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    imem.req   = 1'b0;
    imem.addr  = pc_q;
    if_valid_o = 1'b0;
    instr_o    = '0;
    if_pc_o    = '0;
    buf_load   = 1'b0;
    buf_drop   = 1'b0;
    case (state_q)
      IDLE: state_d = WAIT;
      WAIT: begin
        imem.req = 1'b1;
        if (imem.ack) begin
          // Ack data is offered straight through; IF/ID only takes it when not stalled.
          if_valid_o = 1'b1;
          instr_o    = imem.rdata;
          if_pc_o    = pc_q;
          if (stall_i) begin
            buf_load = 1'b1;
            state_d  = FULL;
          end
        end
      end
      FULL: begin
        if_valid_o = buf_valid;
        instr_o    = buf_instr;
        if_pc_o    = buf_pc;
        if (!stall_i) begin
          buf_drop = 1'b1;
          state_d  = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  npc_fetch_sequencer_fetch_skid_buf #(
    .ADDR_W (ADDR_W)
  ) u_skid_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (buf_load),
    .drop    (buf_drop),
    .instr_d (imem.rdata),
    .pc_d    (pc_q),
    .valid   (buf_valid),
    .instr   (buf_instr),
    .pc      (buf_pc)
  );

endmodule

// File: tb/tb_npc_fetch_sequencer.sv
// Self-checking bench for npc_fetch_sequencer: directed scenarios plus a randomized run,
// all checked against a transaction-level model of the fetch stream.
module tb_npc_fetch_sequencer;
  import npc_fetch_sequencer_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redir_v;
  logic [31:0] redir_t;
  logic        if_valid;
  logic [31:0] instr;
  logic [31:0] if_pc;
  logic [31:0] pc;

  int tests_run    = 0;
  int tests_failed = 0;

  npc_fetch_sequencer_if #(.ADDR_W(32)) imem ();

  npc_fetch_sequencer #(
    .ADDR_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall),
    .redirect_valid_i  (redir_v),
    .redirect_target_i (redir_t),
    .imem              (imem),
    .if_valid_o        (if_valid),
    .instr_o           (instr),
    .if_pc_o           (if_pc),
    .pc_o              (pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: a fetch stream where each new request goes to last+4, or to the
  // redirect target if a redirect arrived since the previous request began.
  logic        m_started, m_out, m_pend;
  logic [31:0] m_last, m_tgt;
  logic [63:0] m_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    m_out     = 1'b0;
    m_pend    = 1'b0;
    m_last    = RST_PC;
    m_tgt     = '0;
    m_q.delete();
  endtask

  task automatic monitor();
    logic [63:0] e;
    if (imem.req) begin
      if (!m_out) begin
        m_last    = m_pend ? m_tgt : (m_started ? m_last + 32'd4 : RST_PC);
        m_pend    = 1'b0;
        m_started = 1'b1;
        m_out     = 1'b1;
      end
      tests_run++;
      if (imem.addr !== m_last) begin
        tests_failed++;
        $display("FAIL fetch_addr: got %h expected %h", imem.addr, m_last);
      end
      tests_run++;
      if (pc !== m_last) begin
        tests_failed++;
        $display("FAIL pc_o: got %h expected %h", pc, m_last);
      end
      if (imem.ack) begin
        m_q.push_back({m_last, mem_word(m_last)});
        m_out = 1'b0;
      end
    end else begin
      tests_run++;
      if (m_out) begin
        tests_failed++;
        $display("FAIL req_dropped: req=0 while fetch of %h outstanding", m_last);
      end
    end
    if (redir_v && !m_pend) begin
      m_pend = 1'b1;
      m_tgt  = redir_t & ~32'd3;
    end
    if (if_valid && !stall) begin
      tests_run++;
      if (m_q.size() == 0) begin
        tests_failed++;
        $display("FAIL spurious_delivery: got pc %h instr %h expected none", if_pc, instr);
      end else begin
        e = m_q.pop_front();
        tests_run++;
        if ({if_pc, instr} !== e) begin
          tests_failed++;
          $display("FAIL delivery: got pc %h instr %h expected pc %h instr %h",
                   if_pc, instr, e[63:32], e[31:0]);
        end
      end
    end
    if (!if_valid && !stall) begin
      tests_run++;
      if (m_q.size() != 0) begin
        tests_failed++;
        $display("FAIL lost_instr: if_valid=0 with %0d undelivered", m_q.size());
      end
    end
    tests_run++;
    if (m_q.size() > 1) begin
      tests_failed++;
      $display("FAIL overflow: %0d instrs buffered expected at most 1", m_q.size());
    end
  endtask

  task automatic step(input logic st, input logic ak, input logic rv, input logic [31:0] rt);
    @(posedge clk);
    #1;
    stall      = st;
    imem.ack   = ak;
    redir_v    = rv;
    redir_t    = rt;
    imem.rdata = ak ? mem_word(imem.addr) : 32'hDEAD_BEEF;
    @(negedge clk);
    monitor();
  endtask

  task automatic assert_reset();
    rst_n      = 1'b0;
    stall      = 1'b0;
    redir_v    = 1'b0;
    redir_t    = '0;
    imem.ack   = 1'b0;
    imem.rdata = '0;
    model_reset();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic apply_reset();
    assert_reset();
    release_reset();
  endtask

  task automatic test_reset();
    assert_reset();
    @(negedge clk);
    tests_run++;
    if ({imem.req, if_valid, instr, if_pc, pc} !== {1'b0, 1'b0, 32'd0, 32'd0, RST_PC}) begin
      tests_failed++;
      $display("FAIL reset_state: got req=%b v=%b instr=%h if_pc=%h pc=%h expected 0 0 0 0 %h",
               imem.req, if_valid, instr, if_pc, pc, RST_PC);
    end
    release_reset();
    @(negedge clk);
    tests_run++;
    if (imem.req !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_req: got %b expected 0", imem.req);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      tests_run++;
      if ({imem.addr, if_valid, if_pc} !== {RST_PC + 32'(4 * i), 1'b1, RST_PC + 32'(4 * i)}) begin
        tests_failed++;
        $display("FAIL seq_fetch: got addr %h v=%b if_pc %h expected %h 1 %h",
                 imem.addr, if_valid, if_pc, RST_PC + 32'(4 * i), RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_in_flight();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_3100);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({if_valid, if_pc} !== {1'b1, 32'h0000_3004}) begin
      tests_failed++;
      $display("FAIL slot_delivery: got v=%b if_pc %h expected 1 00003004", if_valid, if_pc);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    tests_run++;
    if (imem.addr !== 32'h0000_3100) begin
      tests_failed++;
      $display("FAIL redirect_addr: got %h expected 00003100", imem.addr);
    end
  endtask

  task automatic test_stall_full();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      tests_run++;
      if ({imem.req, if_valid, if_pc, instr} !== {1'b0, 1'b1, 32'h0000_3008, mem_word(32'h0000_3008)}) begin
        tests_failed++;
        $display("FAIL full_hold: got req=%b v=%b if_pc %h instr %h expected 0 1 00003008 %h",
                 imem.req, if_valid, if_pc, instr, mem_word(32'h0000_3008));
      end
    end
    step(1'b0, 1'b0, 1'b0, '0);
    tests_run++;
    if ({if_valid, if_pc} !== {1'b1, 32'h0000_3008}) begin
      tests_failed++;
      $display("FAIL full_release: got v=%b if_pc %h expected 1 00003008", if_valid, if_pc);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    tests_run++;
    if (imem.addr !== 32'h0000_300C) begin
      tests_failed++;
      $display("FAIL after_full_addr: got %h expected 0000300c", imem.addr);
    end
  endtask

  task automatic test_redirect_full();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_4000);
    step(1'b1, 1'b0, 1'b0, '0);
    tests_run++;
    if ({imem.req, pc} !== {1'b0, 32'h0000_4000}) begin
      tests_failed++;
      $display("FAIL full_redirect_pc: got req=%b pc %h expected 0 00004000", imem.req, pc);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    tests_run++;
    if (imem.addr !== 32'h0000_4000) begin
      tests_failed++;
      $display("FAIL full_redirect_addr: got %h expected 00004000", imem.addr);
    end
  endtask

  task automatic test_double_redirect();
    apply_reset();
    step(1'b0, 1'b0, 1'b1, 32'h0000_4003);
    step(1'b0, 1'b0, 1'b1, 32'h0000_5000);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    tests_run++;
    if (imem.addr !== 32'h0000_4000) begin
      tests_failed++;
      $display("FAIL double_redirect: got %h expected 00004000", imem.addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    #2 assert_reset();
    #1;
    tests_run++;
    if ({imem.req, if_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL async_reset: got req=%b v=%b expected 0 0", imem.req, if_valid);
    end
    release_reset();
    step(1'b0, 1'b1, 1'b0, '0);
    tests_run++;
    if (imem.addr !== RST_PC) begin
      tests_failed++;
      $display("FAIL restart_addr: got %h expected %h", imem.addr, RST_PC);
    end
  endtask

  task automatic test_random();
    logic        st, ak, rv;
    logic [31:0] rt;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 99) < 30);
      ak = ($urandom_range(0, 99) < 50);
      rv = !m_pend && ($urandom_range(0, 99) < 6);
      rt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(st, ak, rv, rt);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
    end
    tests_run++;
    if (m_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d undelivered expected 0", m_q.size());
    end
  endtask

  initial begin
    assert_reset();
    test_reset();
    test_sequential();
    test_redirect_in_flight();
    test_stall_full();
    test_redirect_full();
    test_double_redirect();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
